rst_seq_ctrl: RTL and testbench

Reset sequencing controller for the system's multi-clock-domain reset tree. It runs in the reference clock domain and releases a set of per-domain active-low reset requests one at a time. Each request feeds that domain's two-flop reset synchronizer. The controller waits for each domain's synchronized-reset acknowledgement before releasing the next domain. It also supports a software-requested soft reset and, optionally, an acknowledgement timeout with an error flag.

---
 rtl/rst_seq_ctrl_if.sv | 28 ++
 rtl/rst_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/rst_seq_ctrl_if.sv
// rst_seq_ctrl_if: sequencing-controller signal bundle.
//   SW_RST_REQ  soft reset request (level or pulse, CLK domain)
//   DOM_RDY     per-domain synchronized-reset acknowledgement
//   DOM_RST_N   per-domain active-low reset request
//   SEQ_BUSY    sequence in progress
//   SEQ_DONE    all domains released and acknowledged
//   SEQ_ERR     acknowledgement timeout occurred
// slave modport faces the controller; master modport faces the system side.
interface rst_seq_ctrl_if #(
  parameter int unsigned NUM_DOMAINS = 2
) ();
  logic                   SW_RST_REQ;
  logic [NUM_DOMAINS-1:0] DOM_RDY;
  logic [NUM_DOMAINS-1:0] DOM_RST_N;
  logic                   SEQ_BUSY;
  logic                   SEQ_DONE;
  logic                   SEQ_ERR;

  modport master (
    output SW_RST_REQ, DOM_RDY,
    input  DOM_RST_N, SEQ_BUSY, SEQ_DONE, SEQ_ERR
  );

  modport slave (
    input  SW_RST_REQ, DOM_RDY,
    output DOM_RST_N, SEQ_BUSY, SEQ_DONE, SEQ_ERR
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: releases per-domain active-low reset requests one at a time,
// waiting for each domain's synchronized acknowledgement before the next.
// Ports:
//   CLK  reference clock
//   RST  asynchronous active-low reset
//   bus  rst_seq_ctrl_if.slave (SW_RST_REQ, DOM_RDY in; DOM_RST_N, SEQ_* out)
// Optional feature: define RST_SEQ_TIMEOUT_EN to enable the acknowledgement
// timeout, the ERR state and SEQ_ERR. Without it WAIT waits indefinitely and
// SEQ_ERR is tied low.
module rst_seq_ctrl #(
  parameter int unsigned NUM_DOMAINS    = 2,
  parameter int unsigned HOLD_CYCLES    = 4,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic          CLK,
  input logic          RST,
  rst_seq_ctrl_if.slave bus
);

  localparam int unsigned MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_ALL = (MAX_HG > TIMEOUT_CYCLES) ? MAX_HG : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_ALL + 1);
  localparam int unsigned IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

  localparam logic [2:0] ST_HOLD = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_GAP  = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd3;
`ifdef RST_SEQ_TIMEOUT_EN
  localparam logic [2:0] ST_ERR  = 3'd4;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  logic [2:0]             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       idx_inc;
  logic [NUM_DOMAINS-1:0] dom_rst_n_q, dom_rst_n_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   soft_rst;
`ifdef RST_SEQ_TIMEOUT_EN
  logic                   err_q, err_d;
`endif

  assign idx_inc = idx_q + IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    dom_rst_n_d = dom_rst_n_q;
    busy_d      = busy_q;
    done_d      = done_q;
    soft_rst    = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
    err_d       = err_q;
`endif

    case (state_q)
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          dom_rst_n_d[0] = 1'b1;
          cnt_d          = '0;
          state_d        = ST_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        // Acknowledgement is tested first so it wins over a same-edge timeout.
        if (bus.DOM_RDY[idx_q]) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_GAP;
          end
        end
`ifdef RST_SEQ_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d            = ST_ERR;
          cnt_d              = '0;
          err_d              = 1'b1;
          busy_d             = 1'b0;
          dom_rst_n_d[idx_q] = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          idx_d                = idx_inc;
          dom_rst_n_d[idx_inc] = 1'b1;
          cnt_d                = '0;
          state_d              = ST_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: soft_rst = bus.SW_RST_REQ;
`ifdef RST_SEQ_TIMEOUT_EN
      ST_ERR:  soft_rst = bus.SW_RST_REQ;
`endif
      // Unreachable encodings recover through a full restart.
      default: soft_rst = 1'b1;
    endcase

    if (soft_rst) begin
      state_d     = ST_HOLD;
      cnt_d       = '0;
      idx_d       = '0;
      dom_rst_n_d = '0;
      busy_d      = 1'b1;
      done_d      = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
      err_d       = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      idx_q       <= '0;
      dom_rst_n_q <= '0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      dom_rst_n_q <= dom_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef RST_SEQ_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign bus.SEQ_ERR = err_q;
`else
  assign bus.SEQ_ERR = 1'b0;
`endif

  assign bus.DOM_RST_N = dom_rst_n_q;
  assign bus.SEQ_BUSY  = busy_q;
  assign bus.SEQ_DONE  = done_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: directed bench for rst_seq_ctrl with NUM_DOMAINS=2,
// HOLD_CYCLES=4, GAP_CYCLES=2, TIMEOUT_CYCLES=8. Edge numbers in the comments
// count rising CLK edges since RST deasserted (or since the soft reset edge).
module tb_rst_seq_ctrl;

  logic CLK;
  logic RST;
  int   edge_n;
  int   total;
  int   bad;

  rst_seq_ctrl_if #(.NUM_DOMAINS(2)) bus ();

  rst_seq_ctrl #(
    .NUM_DOMAINS   (2),
    .HOLD_CYCLES   (4),
    .GAP_CYCLES    (2),
    .TIMEOUT_CYCLES(8)
  ) u_dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
    edge_n++;
  endtask

  task automatic tick_to(input int n);
    while (edge_n < n) tick();
  endtask

  // Asynchronous reset between edges; outputs must change with no clock edge.
  task automatic do_reset(input string tag);
    RST            = 1'b0;
    bus.SW_RST_REQ = 1'b0;
    bus.DOM_RDY    = 2'b00;
    #2;
    check({tag, "_dom"},  32'(bus.DOM_RST_N), 32'h0);
    check({tag, "_busy"}, 32'(bus.SEQ_BUSY),  32'h1);
    check({tag, "_done"}, 32'(bus.SEQ_DONE),  32'h0);
    check({tag, "_err"},  32'(bus.SEQ_ERR),   32'h0);
    @(negedge CLK);
    RST    = 1'b1;
    edge_n = 0;
  endtask

  // Nominal sequence from HOLD entry at edge 'base'; each domain acknowledges
  // on the second edge after its release. sw_busy pulses SW_RST_REQ over
  // edges base+5..base+7, which must have no effect.
  task automatic run_seq(input int base, input logic sw_busy);
    bus.DOM_RDY = 2'b00;
    tick_to(base + 3);
    check("hold_end", 32'(bus.DOM_RST_N), 32'h0);
    tick_to(base + 4);
    check("rel0",      32'(bus.DOM_RST_N), 32'h1);
    check("rel0_busy", 32'(bus.SEQ_BUSY),  32'h1);
    if (sw_busy) bus.SW_RST_REQ = 1'b1;
    tick_to(base + 5);
    bus.DOM_RDY = 2'b01;
    tick_to(base + 7);
    check("gap", 32'(bus.DOM_RST_N), 32'h1);
    bus.SW_RST_REQ = 1'b0;
    tick_to(base + 8);
    check("rel1", 32'(bus.DOM_RST_N), 32'h3);
    tick_to(base + 9);
    check("pre_done", 32'(bus.SEQ_DONE), 32'h0);
    bus.DOM_RDY = 2'b11;
    tick_to(base + 10);
    check("done",      32'(bus.SEQ_DONE),  32'h1);
    check("done_busy", 32'(bus.SEQ_BUSY),  32'h0);
    check("done_err",  32'(bus.SEQ_ERR),   32'h0);
    check("done_dom",  32'(bus.DOM_RST_N), 32'h3);
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    edge_n         = 0;
    RST            = 1'b1;
    bus.SW_RST_REQ = 1'b0;
    bus.DOM_RDY    = 2'b00;
    @(posedge CLK);
    #1;

    // Power-up.
    do_reset("por");
    run_seq(0, 1'b0);

    // Soft reset from DONE, accepted at edge 13.
    tick_to(12);
    check("done_hold", 32'(bus.SEQ_DONE), 32'h1);
    bus.SW_RST_REQ = 1'b1;
    tick_to(13);
    bus.SW_RST_REQ = 1'b0;
    check("sw_dom",  32'(bus.DOM_RST_N), 32'h0);
    check("sw_done", 32'(bus.SEQ_DONE),  32'h0);
    check("sw_busy", 32'(bus.SEQ_BUSY),  32'h1);
    run_seq(13, 1'b0);

    // Soft reset requested while busy is ignored.
    do_reset("rst2");
    run_seq(0, 1'b1);

    // RST mid-sequence, between edges 8 and 9.
    do_reset("rst3");
    tick_to(5);
    bus.DOM_RDY = 2'b01;
    tick_to(8);
    check("mid_pre", 32'(bus.DOM_RST_N), 32'h3);
    do_reset("mid");
    run_seq(0, 1'b0);

    // Domain 1 never acknowledges: released at edge 8, timeout at edge 16.
    do_reset("rst4");
    tick_to(5);
    bus.DOM_RDY = 2'b01;
    tick_to(15);
    check("to_pre_err", 32'(bus.SEQ_ERR),   32'h0);
    check("to_pre_dom", 32'(bus.DOM_RST_N), 32'h3);
    tick_to(16);
`ifdef RST_SEQ_TIMEOUT_EN
    check("to_err",  32'(bus.SEQ_ERR),   32'h1);
    check("to_dom",  32'(bus.DOM_RST_N), 32'h1);
    check("to_busy", 32'(bus.SEQ_BUSY),  32'h0);
    check("to_done", 32'(bus.SEQ_DONE),  32'h0);
    tick_to(20);
    check("err_hold_err", 32'(bus.SEQ_ERR),   32'h1);
    check("err_hold_dom", 32'(bus.DOM_RST_N), 32'h1);
    bus.SW_RST_REQ = 1'b1;
    tick_to(21);
    bus.SW_RST_REQ = 1'b0;
    check("err_sw_dom",  32'(bus.DOM_RST_N), 32'h0);
    check("err_sw_err",  32'(bus.SEQ_ERR),   32'h0);
    check("err_sw_busy", 32'(bus.SEQ_BUSY),  32'h1);
    run_seq(21, 1'b0);
`else
    check("noto_err",  32'(bus.SEQ_ERR),   32'h0);
    check("noto_dom",  32'(bus.DOM_RST_N), 32'h3);
    check("noto_busy", 32'(bus.SEQ_BUSY),  32'h1);
    bus.DOM_RDY = 2'b11;
    tick_to(17);
    check("noto_done", 32'(bus.SEQ_DONE), 32'h1);
`endif

    // Domain 0 acknowledges exactly at the timeout edge (12): no error.
    do_reset("rst5");
    tick_to(11);
    check("late_dom", 32'(bus.DOM_RST_N), 32'h1);
    bus.DOM_RDY = 2'b01;
    tick_to(12);
    check("late_err",  32'(bus.SEQ_ERR),  32'h0);
    check("late_busy", 32'(bus.SEQ_BUSY), 32'h1);
    tick_to(13);
    check("late_gap", 32'(bus.DOM_RST_N), 32'h1);
    tick_to(14);
    check("late_rel1", 32'(bus.DOM_RST_N), 32'h3);
    check("late_err2", 32'(bus.SEQ_ERR),   32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
